// File: rtl/bsg_pkg.sv
// -----------------------------------------------------------------------------
// bsg_pkg
// Shared definitions for the BSG transmit framer:
//   framer_state_t     : frame sequencing states
//   BSG_PREAMBLE_BYTE  : preamble byte value (0x55)
//   BSG_SFD_BYTE       : start-of-frame delimiter (0xD5)
//   BSG_CRC8_POLY      : CRC-8 generator polynomial (x^8+x^2+x+1)
//   crc8_step()        : folds one byte into a running CRC-8 (MSB first,
//                        no reflection, no final XOR)
// Optional feature macro used by the framer: BSG_FRAMER_CRC_EN
// -----------------------------------------------------------------------------
package bsg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_SFD  = 3'd2,
      ST_LEN  = 3'd3,
      ST_PAY  = 3'd4,
      ST_CRC  = 3'd5
   } framer_state_t;

   localparam logic [7:0] BSG_PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0] BSG_SFD_BYTE      = 8'hD5;
   localparam logic [7:0] BSG_CRC8_POLY     = 8'h07;

   // Byte-wide CRC-8 update: XOR the byte into the register, then run eight
   // shift/conditional-XOR steps.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                            input logic [7:0] data_byte);
      logic [7:0] c;
      c = crc ^ data_byte;
      for (int i = 0; i < 8; i++) begin
         if (c[7]) c = {c[6:0], 1'b0} ^ BSG_CRC8_POLY;
         else      c = {c[6:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/bsg_tx_fifo.sv
// -----------------------------------------------------------------------------
// bsg_tx_fifo
// Synchronous payload FIFO for the transmit framer.
// Ports:
//   clk_i       : clock
//   rst_i       : synchronous active-high reset (empties FIFO, clears overflow)
//   push_i      : write request for push_data_i
//   push_data_i : byte to buffer
//   pop_i       : remove the head entry (ignored when empty)
//   head_o      : current head entry (combinational read of the array)
//   full_o      : FIFO holds FIFO_DEPTH entries
//   count_o     : number of buffered entries
//   overflow_o  : sticky, set when a push is dropped
// A push while full is accepted only when a pop happens in the same cycle,
// since the slot being written is the one being freed.
// -----------------------------------------------------------------------------
module bsg_tx_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16,
   localparam int PTR_W     = $clog2(FIFO_DEPTH),
   localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] head_o,
   output logic                  full_o,
   output logic [CNT_W-1:0]      count_o,
   output logic                  overflow_o
);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  push_ok;
   logic                  pop_ok;
   logic                  full;

   assign full    = (count_q == CNT_W'(FIFO_DEPTH));
   assign pop_ok  = pop_i && (count_q != '0);
   assign push_ok = push_i && (!full || pop_ok);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      // Pointers are PTR_W bits and FIFO_DEPTH is a power of two, so the
      // natural binary wrap gives the modulo behaviour.
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
      else if (!push_ok && pop_ok) count_d = count_q - CNT_W'(1);
      if (push_i && !push_ok) overflow_d = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage kept out of the reset path so it maps onto plain RAM.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
   end

   // Head is read combinationally so the next payload byte is presented the
   // cycle after a pop with no bubble.
   assign head_o     = mem_q[rd_ptr_q];
   assign full_o     = full;
   assign count_o    = count_q;
   assign overflow_o = overflow_q;

endmodule

// File: rtl/bsg_tx_framer.sv
// -----------------------------------------------------------------------------
// bsg_tx_framer
// Transmit framer feeding the modulator byte interface. Buffers payload bytes
// in bsg_tx_fifo and, on start, emits:
//   PREAMBLE_LEN x 0x55, 0xD5, LEN, LEN payload bytes [, CRC-8]
// Ports:
//   G_CLK_TX   : transmit clock (rising edge)
//   rst        : synchronous active-high reset
//   wr_en      : push wr_data into the FIFO
//   wr_data    : payload byte
//   start      : request a frame of the current FIFO contents (IDLE only)
//   mod_ready  : downstream accepts data_out this cycle
//   enable     : data_out valid
//   data_out   : frame byte
//   busy       : frame in progress
//   fifo_full  : FIFO holds FIFO_DEPTH bytes
//   fifo_count : bytes buffered
//   overflow   : sticky, a write was dropped
// Configuration macro: BSG_FRAMER_CRC_EN (adds the CRC-8 trailer byte,
// computed over LEN and payload). DATA_WIDTH must be 8.
// -----------------------------------------------------------------------------
module bsg_tx_framer
   import bsg_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int FIFO_DEPTH   = 16,
   parameter int PREAMBLE_LEN = 4,
   localparam int CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  G_CLK_TX,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  start,
   input  logic                  mod_ready,
   output logic                  enable,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  busy,
   output logic                  fifo_full,
   output logic [CNT_W-1:0]      fifo_count,
   output logic                  overflow
);

   framer_state_t         state_q, state_d;
   logic [3:0]            pre_cnt_q, pre_cnt_d;
   logic [CNT_W-1:0]      len_q, len_d;
   logic [CNT_W-1:0]      pay_cnt_q, pay_cnt_d;
   logic [DATA_WIDTH-1:0] fifo_head;
   logic                  active;
   logic                  xfer;
   logic                  pop;
`ifdef BSG_FRAMER_CRC_EN
   logic [7:0]            crc_q, crc_d;
`endif

   assign active = (state_q != ST_IDLE);
   assign xfer   = active && mod_ready;
   // Only payload transfers consume FIFO entries.
   assign pop    = (state_q == ST_PAY) && mod_ready;

   bsg_tx_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (G_CLK_TX),
      .rst_i       (rst),
      .push_i      (wr_en),
      .push_data_i (wr_data),
      .pop_i       (pop),
      .head_o      (fifo_head),
      .full_o      (fifo_full),
      .count_o     (fifo_count),
      .overflow_o  (overflow)
   );

   // Output byte is a pure function of the registered state, so it holds
   // automatically while mod_ready is low.
   always_comb begin
      data_out = '0;
      case (state_q)
         ST_PRE:  data_out = BSG_PREAMBLE_BYTE;
         ST_SFD:  data_out = BSG_SFD_BYTE;
         ST_LEN:  data_out = DATA_WIDTH'(len_q);
         ST_PAY:  data_out = fifo_head;
`ifdef BSG_FRAMER_CRC_EN
         ST_CRC:  data_out = crc_q;
`endif
         default: data_out = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      pre_cnt_d = pre_cnt_q;
      len_d     = len_q;
      pay_cnt_d = pay_cnt_q;
`ifdef BSG_FRAMER_CRC_EN
      crc_d     = crc_q;
`endif
      case (state_q)
         ST_IDLE: begin
            // Length is frozen here; later writes belong to the next frame.
            if (start && (fifo_count != '0)) begin
               len_d     = fifo_count;
               pre_cnt_d = '0;
               pay_cnt_d = '0;
`ifdef BSG_FRAMER_CRC_EN
               crc_d     = 8'h00;
`endif
               state_d   = ST_PRE;
            end
         end
         ST_PRE: begin
            if (xfer) begin
               if (pre_cnt_q == 4'(PREAMBLE_LEN - 1)) state_d = ST_SFD;
               else pre_cnt_d = pre_cnt_q + 4'd1;
            end
         end
         ST_SFD: begin
            if (xfer) state_d = ST_LEN;
         end
         ST_LEN: begin
            if (xfer) begin
`ifdef BSG_FRAMER_CRC_EN
               crc_d   = crc8_step(crc_q, data_out);
`endif
               state_d = ST_PAY;
            end
         end
         ST_PAY: begin
            if (xfer) begin
`ifdef BSG_FRAMER_CRC_EN
               crc_d = crc8_step(crc_q, data_out);
`endif
               if (pay_cnt_q == len_q - CNT_W'(1)) begin
`ifdef BSG_FRAMER_CRC_EN
                  state_d = ST_CRC;
`else
                  state_d = ST_IDLE;
`endif
               end else begin
                  pay_cnt_d = pay_cnt_q + CNT_W'(1);
               end
            end
         end
`ifdef BSG_FRAMER_CRC_EN
         ST_CRC: begin
            if (xfer) state_d = ST_IDLE;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge G_CLK_TX) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pre_cnt_q <= '0;
         len_q     <= '0;
         pay_cnt_q <= '0;
`ifdef BSG_FRAMER_CRC_EN
         crc_q     <= 8'h00;
`endif
      end else begin
         state_q   <= state_d;
         pre_cnt_q <= pre_cnt_d;
         len_q     <= len_d;
         pay_cnt_q <= pay_cnt_d;
`ifdef BSG_FRAMER_CRC_EN
         crc_q     <= crc_d;
`endif
      end
   end

   assign enable = active;
   assign busy   = active;

endmodule

// File: tb/tb_bsg_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_bsg_tx_framer
// Bench for bsg_tx_framer (default parameters). A frame-level reference model
// (byte queues) predicts every output each cycle; directed scenarios pin the
// model with literal byte sequences. Honours BSG_FRAMER_CRC_EN.
// -----------------------------------------------------------------------------
module tb_bsg_tx_framer;

   localparam int P  = 4;
   localparam int D  = 16;
   localparam int CW = $clog2(D + 1);
`ifdef BSG_FRAMER_CRC_EN
   localparam int CRC_ON = 1;
`else
   localparam int CRC_ON = 0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic [7:0]    wr_data = 8'h00;
   logic          start = 1'b0;
   logic          mod_ready = 1'b0;
   logic          enable;
   logic [7:0]    data_out;
   logic          busy;
   logic          fifo_full;
   logic [CW-1:0] fifo_count;
   logic          overflow;

   bsg_tx_framer #(.DATA_WIDTH(8), .FIFO_DEPTH(D), .PREAMBLE_LEN(P)) dut (
      .G_CLK_TX   (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .start      (start),
      .mod_ready  (mod_ready),
      .enable     (enable),
      .data_out   (data_out),
      .busy       (busy),
      .fifo_full  (fifo_full),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // CRC-8 (poly 0x07) as a serial bit-by-bit LFSR over the whole message.
   function automatic logic [7:0] crc_ref(input logic [7:0] msg[$]);
      logic [7:0] r;
      logic       fb;
      r = 8'h00;
      foreach (msg[k]) begin
         for (int b = 7; b >= 0; b--) begin
            fb = r[7] ^ msg[k][b];
            r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
         end
      end
      return r;
   endfunction

   // Reference model state
   logic [7:0] mq[$];     // buffered payload bytes
   logic [8:0] fq[$];     // remaining frame bytes, bit 8 = payload (pops FIFO)
   bit         ovf_m = 1'b0;
   // Bytes observed on the DUT interface at transfer edges
   logic [7:0] sent[$];
   bit         en_s = 1'b0;
   logic [7:0] do_s = 8'h00;

   always @(posedge clk) begin : model_and_compare
      bit         was_active;
      bit         popm;
      int         cnt0;
      logic [8:0] it;
      logic [7:0] tmp;
      logic [7:0] msg[$];
      if (rst) begin
         mq.delete();
         fq.delete();
         ovf_m = 1'b0;
      end else begin
         if (en_s && mod_ready) sent.push_back(do_s);
         cnt0       = mq.size();
         was_active = (fq.size() != 0);
         popm       = 1'b0;
         if (was_active && mod_ready) begin
            it = fq.pop_front();
            if (it[8]) begin
               tmp  = mq.pop_front();
               popm = 1'b1;
            end
         end
         if (wr_en) begin
            if (cnt0 < D || popm) mq.push_back(wr_data);
            else ovf_m = 1'b1;
         end
         if (!was_active && start && cnt0 != 0) begin
            msg.delete();
            for (int i = 0; i < P; i++) fq.push_back({1'b0, 8'h55});
            fq.push_back({1'b0, 8'hD5});
            fq.push_back({1'b0, 8'(cnt0)});
            msg.push_back(8'(cnt0));
            for (int i = 0; i < cnt0; i++) begin
               fq.push_back({1'b1, mq[i]});
               msg.push_back(mq[i]);
            end
            if (CRC_ON != 0) fq.push_back({1'b0, crc_ref(msg)});
         end
      end
      #1;
      chk("enable", int'(enable), int'(fq.size() != 0));
      chk("busy", int'(busy), int'(fq.size() != 0));
      chk("fifo_count", int'(fifo_count), mq.size());
      chk("fifo_full", int'(fifo_full), int'(mq.size() == D));
      chk("overflow", int'(overflow), int'(ovf_m));
      if (fq.size() != 0) chk("data_out", int'(data_out), int'(fq[0][7:0]));
      en_s = enable;
      do_s = data_out;
   end

   task automatic push_byte(input logic [7:0] v);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = v;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic wait_idle(input int lim);
      int n;
      n = 0;
      while (busy && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk("idle_wait", int'(busy), 0);
      $display("frame done: %0d bytes observed", sent.size());
   endtask

   task automatic send_frame();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle(300);
   endtask

   task automatic cmp_seq(input string nm, input logic [7:0] exp[$]);
      chk({nm, "_len"}, sent.size(), exp.size());
      for (int i = 0; i < exp.size() && i < sent.size(); i++)
         chk(nm, int'(sent[i]), int'(exp[i]));
   endtask

   initial begin
      logic [7:0] e[$];
      logic [7:0] m[$];
      int bc;
      int nb;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_enable", int'(enable), 0);
      chk("rst_data_out", int'(data_out), 0);
      chk("rst_count", int'(fifo_count), 0);
      rst = 1'b0;
      mod_ready = 1'b1;

      // Basic frame: one payload byte 0x01
      push_byte(8'h01);
      sent.delete();
      send_frame();
      e = '{8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'h01, 8'h01};
      if (CRC_ON != 0) e.push_back(8'h12);
      cmp_seq("basic", e);

      // Backpressure with mid-frame start re-pulse
      push_byte(8'hA0);
      push_byte(8'hA1);
      push_byte(8'hA2);
      sent.delete();
      @(negedge clk);
      start = 1'b1;
      mod_ready = 1'b0;
      bc = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (busy) bc++;
         else if (n > 0) break;
         mod_ready = ~mod_ready;
         start = (n == 4);
      end
      start = 1'b0;
      mod_ready = 1'b1;
      chk("bp_idle", int'(busy), 0);
      e = '{8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'h03, 8'hA0, 8'hA1, 8'hA2};
      m = '{8'h03, 8'hA0, 8'hA1, 8'hA2};
      if (CRC_ON != 0) e.push_back(crc_ref(m));
      nb = e.size();
      cmp_seq("backpressure", e);
      chk("bp_cycles", int'(bc >= 2 * nb - 1 && bc <= 2 * nb), 1);
      $display("frame done: %0d bytes in %0d busy cycles", sent.size(), bc);

      // Overflow: D+1 pushes while idle
      for (int i = 0; i <= D; i++) begin
         @(negedge clk);
         wr_en   = 1'b1;
         wr_data = 8'(8'h10 + i);
      end
      @(negedge clk);
      wr_en = 1'b0;
      chk("ovf_full", int'(fifo_full), 1);
      chk("ovf_count", int'(fifo_count), D);
      chk("ovf_flag", int'(overflow), 1);
      sent.delete();
      send_frame();
      chk("ovf_len", sent.size(), P + 2 + D + CRC_ON);
      if (sent.size() >= P + 2 + D) begin
         chk("ovf_lenbyte", int'(sent[P + 1]), D);
         chk("ovf_first", int'(sent[P + 2]), 8'h10);
         chk("ovf_last", int'(sent[P + 1 + D]), 8'h1F);
      end

      // Start with an empty FIFO is ignored
      sent.delete();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("empty_start_en", int'(enable), 0);
      repeat (3) @(negedge clk);
      chk("empty_start_sent", sent.size(), 0);

      // Write during PAY goes to the next frame
      push_byte(8'h31);
      push_byte(8'h32);
      sent.delete();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (P + 2) @(negedge clk);
      wr_en   = 1'b1;
      wr_data = 8'h77;
      @(negedge clk);
      wr_en   = 1'b0;
      wait_idle(100);
      chk("mid_len", sent.size(), P + 4 + CRC_ON);
      if (sent.size() >= P + 4) begin
         chk("mid_lenbyte", int'(sent[P + 1]), 2);
         chk("mid_pay1", int'(sent[P + 3]), 8'h32);
      end
      chk("mid_count", int'(fifo_count), 1);
      sent.delete();
      send_frame();
      if (sent.size() >= P + 3) begin
         chk("second_lenbyte", int'(sent[P + 1]), 1);
         chk("second_pay", int'(sent[P + 2]), 8'h77);
      end else begin
         chk("second_len", sent.size(), P + 3 + CRC_ON);
      end

      // Reset during PAY (overflow still set from earlier)
      push_byte(8'h41);
      push_byte(8'h42);
      push_byte(8'h43);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (P + 2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_enable", int'(enable), 0);
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_count", int'(fifo_count), 0);
      chk("rst_mid_ovf", int'(overflow), 0);
      rst = 1'b0;
      $display("reset mid-frame applied");

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         wr_en     = ($urandom_range(0, 2) == 0);
         wr_data   = 8'($urandom);
         start     = ($urandom_range(0, 19) == 0);
         mod_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 499) == 0);
      end
      @(negedge clk);
      wr_en = 1'b0;
      start = 1'b0;
      rst = 1'b0;
      mod_ready = 1'b1;
      wait_idle(300);
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
